fc_relu_requant: RTL
====================

FC_RELU_REQUANT -- requirements
Module: fc_relu_requant

Interface
REQ-001 Parameter N, default 8: activation bit-width; output element width.
REQ-002 Parameter J, default 3: rows, i.e. number of matrix-vector result elements.
REQ-003 Parameter K, default 3: vector dimension of the upstream product.
REQ-004 Parameter L, default 2*(N-1)+K: signed width of each incoming row result.
REQ-005 Parameter SHIFT, default N-1: arithmetic right-shift amount for requantization; legal range 0..L-1.
REQ-006 clk  input  1: sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1: reset; asynchronous assertion, active-low.
REQ-008 in_valid  input  1: wx and bias are valid this cycle.
REQ-009 in_ready  output  1: block can accept a vector.
REQ-010 wx  input  J*L: packed signed row results; row r occupies bits [(r+1)*L-1 -: L].
REQ-011 bias  input  J*L: packed signed per-row bias; same packing as wx.
REQ-012 out_valid  output  1: out_data and sat_flags hold a complete result.
REQ-013 out_ready  input  1: consumer accepts the result this cycle.
REQ-014 out_data  output  J*N: packed signed N-bit activations; row r at bits [(r+1)*N-1 -: N], directly usable as the next layer's e_input.
REQ-015 sat_flags  output  J: bit r set when row r saturated.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, PROC, DONE.
REQ-017 in_ready SHALL be 1 in IDLE only, and 0 in PROC and DONE.
REQ-018 In IDLE, an in_valid&&in_ready handshake SHALL capture wx and bias into internal registers, clear the row counter to 0, and move to PROC.
REQ-019 In PROC, the block SHALL process exactly one row per cycle, selected by row counter r, and write the result into out_data row r and sat_flags[r].
REQ-020 Per row, sum SHALL be wx[r]+bias[r], sign-extended to L+1 bits, so no overflow is possible.
REQ-021 If sum<0, the row result SHALL be 0 with the flag clear (ReLU).
REQ-022 Otherwise, q = sum>>>SHIFT; if q>2^(N-1)-1, the result SHALL be 2^(N-1)-1 with the flag set; else the result is q[N-1:0] with the flag clear.
REQ-023 When the row counter reaches J-1, the FSM SHALL move to DONE on that edge; the counter SHALL not wrap inside PROC.
REQ-024 out_valid SHALL be 1 exactly in DONE. Latency from the accepting edge to out_valid high SHALL be J cycles.
REQ-025 In DONE, out_data and sat_flags SHALL be held stable until out_ready is 1; the FSM then moves to IDLE on that edge.
REQ-026 Throughput SHALL be one vector per J+2 cycles with out_ready held high.
REQ-027 in_valid in PROC or DONE SHALL be ignored; the input is neither captured nor disturbs state.
REQ-028 Rows not yet processed in PROC SHALL retain their previous values; they are not observable because out_valid is 0.
REQ-029 SHIFT=0 SHALL pass non-negative sums unshifted, subject to saturation.

Reset
REQ-030 While rst_n is 0, the following SHALL hold immediately, independent of clk: FSM=IDLE, row counter=0, out_data=0, sat_flags=0, out_valid=0, captured registers=0.
REQ-031 in_ready SHALL be 1 during and after reset.
REQ-032 Reset asserted mid-PROC or mid-DONE SHALL abort the vector without emitting output; the first accept after release starts a fresh vector.

Verification
REQ-033 Nominal (N=8, J=3, L=17, SHIFT=4): wx rows {100,-50,5000}, bias {28,10,0}, out_ready=1 -> out_valid 3 cycles after accept; rows {8,0,127}; sat_flags=3'b100.
REQ-034 Backpressure: same stimulus with out_ready=0 for 5 cycles in DONE -> out_data and out_valid stable all 5 cycles, in_ready=0; IDLE one cycle after out_ready=1.
REQ-035 Extremes: wx rows {-65536,65535,0}, bias {-65536,65535,-1} -> rows {0,127,0}; sat_flags=3'b010.
REQ-036 Ignored input: second in_valid pulse with different data during PROC -> output equals the first vector's result only.
REQ-037 Reset mid-operation: rst_n low in PROC cycle 2 -> out_valid=0 and out_data=0 asynchronously; after release, a new vector {16,16,16} with bias 0 and SHIFT=4 -> rows {1,1,1}.
REQ-038 Back-to-back: 4 vectors with in_valid and out_ready held high -> accepts spaced exactly 5 cycles apart; results match a reference model.

Source files
------------

// File: rtl/fc_relu_requant_if.sv
// Stream bundle for fc_relu_requant: one packed input vector (wx + bias) in,
// one packed activation vector plus per-row saturation flags out.
interface fc_relu_requant_if #(
  parameter int N = 8,
  parameter int J = 3,
  parameter int L = 2 * (N - 1) + 3
);
  logic             in_valid;
  logic             in_ready;
  logic [J*L-1:0]   wx;
  logic [J*L-1:0]   bias;
  logic             out_valid;
  logic             out_ready;
  logic [J*N-1:0]   out_data;
  logic [J-1:0]     sat_flags;

  modport master (
    output in_valid, wx, bias, out_ready,
    input  in_ready, out_valid, out_data, sat_flags
  );

  modport slave (
    input  in_valid, wx, bias, out_ready,
    output in_ready, out_valid, out_data, sat_flags
  );
endinterface

// File: rtl/fc_relu_requant.sv
// Bias add, ReLU and shift-requantize of J row results, one row per cycle,
// producing saturated signed N-bit activations for the next layer.
module fc_relu_requant #(
  parameter int N     = 8,
  parameter int J     = 3,
  parameter int K     = 3,
  parameter int L     = 2 * (N - 1) + K,
  parameter int SHIFT = N - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fc_relu_requant_if.slave bus
);

  localparam int RW = (J > 1) ? $clog2(J) : 1;
  // Largest positive N-bit activation, widened to the L+1 bit sum domain.
  localparam logic signed [L:0] MAX_Q = {{(L + 2 - N){1'b0}}, {(N - 1){1'b1}}};

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t           state_reg;
  logic [RW-1:0]    row_reg;
  logic [J*L-1:0]   wx_reg;
  logic [J*L-1:0]   bias_reg;
  logic [J*N-1:0]   out_data_reg;
  logic [J-1:0]     sat_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic signed [L-1:0] wx_arr   [J];
  logic signed [L-1:0] bias_arr [J];

  genvar gi;
  generate
    for (gi = 0; gi < J; gi++) begin : g_unpack
      assign wx_arr[gi]   = $signed(wx_reg[gi*L +: L]);
      assign bias_arr[gi] = $signed(bias_reg[gi*L +: L]);
    end
  endgenerate

  logic signed [L-1:0] wx_row;
  logic signed [L-1:0] bias_row;
  logic signed [L:0]   sum_row;
  logic signed [L:0]   q_row;
  logic [N-1:0]        res_row;
  logic                sat_row;

  assign wx_row   = wx_arr[row_reg];
  assign bias_row = bias_arr[row_reg];
  // One extra bit of headroom makes the add overflow-free.
  assign sum_row  = $signed({wx_row[L-1], wx_row}) + $signed({bias_row[L-1], bias_row});
  assign q_row    = sum_row >>> SHIFT;

  always_comb begin
    res_row = '0;
    sat_row = 1'b0;
    if (!sum_row[L]) begin
      if (q_row > MAX_Q) begin
        res_row = MAX_Q[N-1:0];
        sat_row = 1'b1;
      end else begin
        res_row = q_row[N-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      wx_reg        <= '0;
      bias_reg      <= '0;
      out_data_reg  <= '0;
      sat_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            wx_reg       <= bus.wx;
            bias_reg     <= bus.bias;
            row_reg      <= '0;
            state_reg    <= PROC;
            in_ready_reg <= 1'b0;
          end
        end
        PROC: begin
          for (int r = 0; r < J; r++) begin
            if (row_reg == RW'(r)) begin
              out_data_reg[r*N +: N] <= res_row;
              sat_reg[r]             <= sat_row;
            end
          end
          if (row_reg == RW'(J - 1)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            row_reg <= row_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.sat_flags = sat_reg;

endmodule
